// File: rtl/data_mem_pkg.sv
// Shared widths and arbiter state encoding for the data-memory arbiter.
package data_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Map a port index onto its ownership state.
  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side bundle between two masters, the arbiter and data_mem.
interface data_mem_arbiter_if;
  import data_mem_pkg::*;

  // Port 0 (core)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  // Port 1 (loader)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  // Memory side
  logic [ADDR_W-1:0] DataAddress;
  logic              ReadMem;
  logic              WriteMem;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;

  // Requesters and memory as seen from outside the arbiter.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output DataOut,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  DataAddress, ReadMem, WriteMem, DataIn
  );

  // The arbiter itself.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  DataOut,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output DataAddress, ReadMem, WriteMem, DataIn
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for a single-ported data memory: bounded bursts with
// round-robin tie breaking and registered read-data return per port.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input logic              CLK,
  input logic              reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [3:0] CntMax = 4'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt0, gnt1;
  logic rd0, rd1;

  // Grants are gated by reset so nothing reaches memory on a reset edge.
  always_comb begin
    gnt0 = (state_q == OWN0) && bus.req0 && !reset;
    gnt1 = (state_q == OWN1) && bus.req1 && !reset;
    rd0  = gnt0 && !bus.we0;
    rd1  = gnt1 && !bus.we1;
  end

  always_comb begin
    bus.DataAddress = '0;
    bus.DataIn      = '0;
    bus.WriteMem    = 1'b0;
    bus.ReadMem     = 1'b0;
    if (gnt0) begin
      bus.DataAddress = bus.addr0;
      bus.DataIn      = bus.wdata0;
      bus.WriteMem    = bus.we0;
      bus.ReadMem     = !bus.we0;
    end else if (gnt1) begin
      bus.DataAddress = bus.addr1;
      bus.DataIn      = bus.wdata1;
      bus.WriteMem    = bus.we1;
      bus.ReadMem     = !bus.we1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = own_state(!last_q);
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? OWN1 : IDLE;
        end else if (cnt_q == CntMax && bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? OWN0 : IDLE;
        end else if (cnt_q == CntMax && bus.req0) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Staying in an OWN state implies the owner was granted this cycle.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d == OWN0) begin
        last_d = 1'b0;
      end else if (state_d == OWN1) begin
        last_d = 1'b1;
      end
    end else if (state_q != IDLE && cnt_q != CntMax) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_comb begin
    rvalid0_d = rd0;
    rvalid1_d = rd1;
    rdata0_d  = rd0 ? bus.DataOut : rdata0_q;
    rdata1_d  = rd1 ? bus.DataOut : rdata1_q;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

  gnt_onehot_a: assert property (@(posedge CLK) !(gnt0 && gnt1));
  quiet_when_idle_a: assert property (@(posedge CLK)
    !(gnt0 || gnt1) |-> !(bus.ReadMem || bus.WriteMem));
  quiet_in_reset_a: assert property (@(posedge CLK)
    reset |-> !(gnt0 || gnt1 || bus.ReadMem || bus.WriteMem));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed and constrained-random bench for data_mem_arbiter against an
// ownership/reference-memory model.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int unsigned MaxBurst = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();

  data_mem_arbiter #(.MAX_BURST(MaxBurst)) dut (
    .CLK  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment memory (stands in for data_mem).
  logic       mem_init = 1'b1;
  logic [7:0] mem [256];
  assign bus.DataOut = mem[bus.DataAddress];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (bus.WriteMem) begin
      mem[bus.DataAddress] <= bus.DataIn;
    end
  end

  // Reference model: who owns the memory and how many grants this tenure.
  logic       model_on = 1'b0;
  int         m_owner = -1;
  int         m_run = 0;
  int         m_last = 1;
  logic       m_rv0, m_rv1;
  logic [7:0] m_rd0, m_rd1;
  logic [7:0] ref_mem [256];

  function automatic logic req_of(input int p);
    return (p == 0) ? bus.req0 : bus.req1;
  endfunction

  function automatic logic exp_gnt(input int p);
    return !reset && (m_owner == p) && req_of(p);
  endfunction

  function automatic int next_owner();
    int o;
    if (m_owner < 0) begin
      if (bus.req0 && bus.req1) return 1 - m_last;
      if (bus.req0) return 0;
      if (bus.req1) return 1;
      return -1;
    end
    o = m_owner;
    if (!req_of(o)) return req_of(1 - o) ? (1 - o) : -1;
    if (req_of(1 - o) && (m_run + 1 >= int'(MaxBurst))) return 1 - o;
    return o;
  endfunction

  always @(posedge clk) begin : model
    int   nxt;
    logic g0, g1;
    g0  = exp_gnt(0);
    g1  = exp_gnt(1);
    nxt = next_owner();
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= 8'(i * 7 + 3);
    end
    if (reset) begin
      m_owner <= -1;
      m_run   <= 0;
      m_last  <= 1;
      m_rv0   <= 1'b0;
      m_rv1   <= 1'b0;
      m_rd0   <= 8'h00;
      m_rd1   <= 8'h00;
    end else begin
      m_owner <= nxt;
      m_run   <= (nxt == m_owner) ? m_run + 1 : 0;
      if (nxt != m_owner && nxt >= 0) m_last <= nxt;
      m_rv0 <= g0 && !bus.we0;
      m_rv1 <= g1 && !bus.we1;
      if (g0 && !bus.we0) m_rd0 <= ref_mem[bus.addr0];
      if (g1 && !bus.we1) m_rd1 <= ref_mem[bus.addr1];
      if (g0 && bus.we0) ref_mem[bus.addr0] <= bus.wdata0;
      if (g1 && bus.we1) ref_mem[bus.addr1] <= bus.wdata1;
    end
  end

  // Per-cycle comparison against the model, plus fairness bound.
  int s0 = 0;
  int s1 = 0;
  always @(negedge clk) begin : compare
    logic       e0, e1;
    logic [7:0] ea, ed;
    if (model_on) begin
      e0 = exp_gnt(0);
      e1 = exp_gnt(1);
      ea = e0 ? bus.addr0 : (e1 ? bus.addr1 : 8'h00);
      ed = e0 ? bus.wdata0 : (e1 ? bus.wdata1 : 8'h00);
      chk("gnt0", bus.gnt0, e0);
      chk("gnt1", bus.gnt1, e1);
      chk("gnt_onehot", bus.gnt0 && bus.gnt1, 1'b0);
      chk("DataAddress", bus.DataAddress, ea);
      chk("DataIn", bus.DataIn, ed);
      chk("WriteMem", bus.WriteMem, (e0 && bus.we0) || (e1 && bus.we1));
      chk("ReadMem", bus.ReadMem, (e0 && !bus.we0) || (e1 && !bus.we1));
      chk("rvalid0", bus.rvalid0, m_rv0);
      chk("rvalid1", bus.rvalid1, m_rv1);
      chk("rdata0", bus.rdata0, m_rd0);
      chk("rdata1", bus.rdata1, m_rd1);
      s0 = (bus.gnt0 && bus.req1) ? s0 + 1 : (bus.gnt0 ? s0 : 0);
      s1 = (bus.gnt1 && bus.req0) ? s1 + 1 : (bus.gnt1 ? s1 : 0);
      if (bus.gnt0 && bus.req1) chk("burst0_bound", s0 <= int'(MaxBurst), 1'b1);
      if (bus.gnt1 && bus.req0) chk("burst1_bound", s1 <= int'(MaxBurst), 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
  endtask

  initial begin : stim
    int   cnt;
    int   exp_p;
    logic gl0, gl1;

    reset = 1'b1;
    idle_inputs();
    step();
    mem_init = 1'b0;
    model_on = 1'b1;

    // Reset values, then a P0 write and read-back of address 16.
    neg();
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_wmem", bus.WriteMem, 1'b0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_rdata0", bus.rdata0, 8'h00);
    step();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'd16; bus.wdata0 = 8'd254;
    neg();
    chk("t1_no_gnt_yet", bus.gnt0, 1'b0);
    step();
    neg();
    chk("t1_gnt0", bus.gnt0, 1'b1);
    chk("t1_gnt1", bus.gnt1, 1'b0);
    chk("t1_wmem", bus.WriteMem, 1'b1);
    chk("t1_addr", bus.DataAddress, 8'd16);
    chk("t1_din", bus.DataIn, 8'd254);
    step();
    bus.we0 = 1'b0;
    neg();
    chk("t1_mem16", mem[16], 8'd254);
    chk("t1_rd_gnt", bus.gnt0, 1'b1);
    chk("t1_rmem", bus.ReadMem, 1'b1);
    chk("t1_rd_addr", bus.DataAddress, 8'd16);
    step();
    bus.req0 = 1'b0;
    neg();
    chk("t1_rvalid", bus.rvalid0, 1'b1);
    chk("t1_rdata", bus.rdata0, 8'd254);
    step();
    neg();
    chk("t1_rvalid_once", bus.rvalid0, 1'b0);
    chk("t1_rdata_hold", bus.rdata0, 8'd254);

    // Simultaneous requests after reset: 4/4/4 alternation starting with P0.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 8'd1;
    bus.req1 = 1'b1; bus.addr1 = 8'd2;
    for (int k = 0; k < 13; k++) begin
      neg();
      exp_p = (k == 0) ? -1 : (((k - 1) / 4) % 2);
      chk("t2_gnt0", bus.gnt0, exp_p == 0);
      chk("t2_gnt1", bus.gnt1, exp_p == 1);
      step();
    end
    idle_inputs();

    // Lone P1 requester keeps ownership.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req1 = 1'b1; bus.addr1 = 8'd5;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      neg();
      if (bus.gnt1) cnt++;
      step();
    end
    chk("t3_grants", cnt, 9);
    bus.req1 = 1'b0;
    neg();
    chk("t3_drop_gnt1", bus.gnt1, 1'b0);
    step();
    neg();
    chk("t3_idle_rmem", bus.ReadMem, 1'b0);
    chk("t3_idle_wmem", bus.WriteMem, 1'b0);
    chk("t3_idle_addr", bus.DataAddress, 8'h00);

    // Reset in the middle of a P1 write burst.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'd244; bus.wdata1 = 8'd5;
    repeat (3) begin
      neg();
      step();
    end
    reset = 1'b1;
    bus.wdata1 = 8'd9;
    neg();
    chk("t4_rst_wmem", bus.WriteMem, 1'b0);
    chk("t4_rst_gnt1", bus.gnt1, 1'b0);
    step();
    reset = 1'b0;
    neg();
    chk("t4_mem244", mem[244], 8'd5);
    chk("t4_idle_gnt1", bus.gnt1, 1'b0);
    chk("t4_rvalid1", bus.rvalid1, 1'b0);
    step();
    neg();
    chk("t4_regrant", bus.gnt1, 1'b1);
    chk("t4_din", bus.DataIn, 8'd9);
    step();
    neg();
    chk("t4_mem244_new", mem[244], 8'd9);
    idle_inputs();
    step();

    // Random traffic; requests held until granted.
    gl0 = 1'b0;
    gl1 = 1'b0;
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 99) < 2);
      if (!bus.req0 || gl0) begin
        bus.req0   = ($urandom_range(0, 99) < 70);
        bus.we0    = 1'($urandom_range(0, 1));
        bus.addr0  = 8'($urandom_range(0, 15));
        bus.wdata0 = 8'($urandom);
      end
      if (!bus.req1 || gl1) begin
        bus.req1   = ($urandom_range(0, 99) < 70);
        bus.we1    = 1'($urandom_range(0, 1));
        bus.addr1  = 8'($urandom_range(0, 15));
        bus.wdata1 = 8'($urandom);
      end
      neg();
      gl0 = bus.gnt0;
      gl1 = bus.gnt1;
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, max consecutive accesses by one owner while the other port is requesting; legal range 1..15.
REQ-002 Port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Ports per requester x in {0,1} (P0 = core, P1 = loader): reqx input 1 request; wex input 1 write=1/read=0; addrx input 8 address; wdatax input 8 write data.
REQ-005 Ports per requester x: gntx output 1 access issued this cycle; rvalidx output 1 rdatax valid; rdatax output 8 read data.
REQ-006 Memory side: DataAddress output 8; ReadMem output 1; WriteMem output 1; DataIn output 8; DataOut input 8 (combinational read data from data_mem).

Function
REQ-007 The block SHALL have states IDLE, OWN0, OWN1, held in a registered state variable.
REQ-008 gntx SHALL be combinational: 1 iff state==OWNx and reqx==1 and reset==0.
REQ-009 At most one of gnt0/gnt1 SHALL be 1 in any cycle.
REQ-010 When gntx==1: DataAddress=addrx, DataIn=wdatax, WriteMem=wex, ReadMem=!wex; otherwise all four memory outputs SHALL be 0.
REQ-011 A granted write SHALL commit to memory at the same posedge (zero added latency).
REQ-012 On a granted read, DataOut SHALL be registered into rdatax at that posedge; rvalidx SHALL be 1 for exactly the following cycle.
REQ-013 rdatax SHALL hold its value until the next granted read by port x.
REQ-014 IDLE: req0&req1 -> OWN of the port not equal to last; only reqx -> OWNx; neither -> IDLE. The first access is granted 1 cycle after req rises.
REQ-015 OWNx with reqx==0: req of other port -> OWN(other); else -> IDLE.
REQ-016 OWNx with reqx==1: if cnt==MAX_BURST-1 and the other req==1 -> OWN(other); else stay, cnt SHALL increment, saturating at MAX_BURST-1.
REQ-017 cnt (4 bits) SHALL clear to 0 on every state change.
REQ-018 last (1 bit) SHALL be set to x on every entry into OWNx.
REQ-019 A lone requester SHALL keep ownership indefinitely (no forced yield).
REQ-020 Requesters SHALL hold we/addr/wdata stable while req is high and gnt is low; the block does not buffer requests.

Reset
REQ-021 While reset==1: state SHALL go to IDLE, cnt=0, last=1 (P0 wins the first tie), rvalid0/1=0, rdata0/1=0.
REQ-022 While reset==1, gnt0/gnt1, ReadMem and WriteMem SHALL be 0 in the same cycle, so no write commits at a reset edge.
REQ-023 Reset mid-burst SHALL discard ownership, with no rvalid in the cycle after reset.

Structure
REQ-024 Package data_mem_pkg SHALL hold ADDR_W=8, DATA_W=8, and the enum arb_state_e {IDLE, OWN0, OWN1}.
REQ-025 The block SHALL be a single module with no sub-module; it instantiates nothing and connects beside data_mem at the top level.

Verification
REQ-026 Reset, then req0=1 we0=1 addr0=16 wdata0=254 -> gnt0 one cycle after req; M[16]=254; gnt1 stays 0.
REQ-027 P0 read of addr 16 -> ReadMem=1, DataAddress=16 during gnt0; rvalid0=1 and rdata0=254 on the next cycle only.
REQ-028 req0 and req1 rise together after reset -> P0 owns first; both held -> 4 gnt0, then 4 gnt1, then 4 gnt0 (MAX_BURST=4).
REQ-029 Only req1 held for 10 cycles -> gnt1=1 for 9 consecutive cycles, no yield; req1 drops -> IDLE, memory outputs 0.
REQ-030 reset asserted during a P1 write burst (we1=1, addr1=244, wdata1=5) -> WriteMem=0 in the reset cycle; after release: IDLE, rvalid=0, then a fresh arbitration.
REQ-031 Random req/we/addr traffic with a reference memory model -> gnt one-hot-or-zero every cycle; every rdata matches the model; no port is starved beyond MAX_BURST grants.
